turbo_sched: RTL and testbench
==============================

TURBO_SCHED -- requirements
Module: turbo_sched

Interface
REQ-001 SHALL have parameter PORTFE_HOLD, default 12'd4095, ck35 ticks turbo is suppressed after a port #FE access (about 1170 us).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 4'd8, clk28 cycles the clock generator is frozen after a speed change.
REQ-003 SHALL have ports, clock and reset first:
- clk28  input  1  28 MHz system clock
- rst  input  1  asynchronous, active-high reset
- ck35  input  1  3.5 MHz strobe, one clk28 cycle wide
- bus  input  cpu_bus  CPU bus (a, mreq, ioreq, m1, rd, wr)
- cfg_turbo  input  turbo_t  speed chosen in the magic config
- autoturbo_en  input  1  enables the automatic sources
- div_paged  input  1  DivMMC ROM paged in
- magic_map  input  1  magic ROM mapped
- basic48_paged  input  1  48K BASIC ROM paged in
- turbo  output  turbo_t  speed applied to the clock generator
- clk_freeze  output  1  clock generator SHALL hold its phase while high
- busy  output  1  a change is pending or settling
- src  output  2  winning source: 0 cfg, 1 basic48, 2 portfe, 3 div

Function
REQ-004 Port #FE timer (12 bit): loaded to 1 on any cycle with bus.ioreq && !bus.a[0].
- Otherwise increments on ck35 while non-zero.
- Wraps 4095->0, which ends suppression.
- A reload during counting restarts the count from 1.
REQ-005 basic48 flag: set when basic48_paged && bus.m1 && bus.a[15:6]==10'b0001000111.
- Cleared when !basic48_paged, or on an m1 cycle outside that range.
- Set has priority over clear in the same cycle.
REQ-006 Requested speed, evaluated every clk28, fixed priority:
- autoturbo_en && div_paged && !magic_map -> TURBO_14, src=3
- else autoturbo_en && port #FE timer non-zero -> TURBO_NONE, src=2
- else autoturbo_en && basic48 flag -> TURBO_14, src=1
- else cfg_turbo, src=0
REQ-007 State machine, reset state IDLE:
- IDLE: if requested != turbo, go to WAIT.
- WAIT: on a ck35 strobe with !bus.mreq && !bus.ioreq (safe point), load turbo with the requested value, latch src, set clk_freeze=1, load the settle counter with SETTLE_CYCLES, go to SETTLE.
- SETTLE: decrement the counter each clk28; at 1, clear clk_freeze and go to IDLE.
REQ-008 Requests are re-sampled at the safe point, so the latest requested value is applied, not the one that caused entry to WAIT.
REQ-009 If the request returns to equal turbo while in WAIT, go back to IDLE with no change and no freeze.
REQ-010 Request changes during SETTLE SHALL be ignored until SETTLE ends, then handled from IDLE; at most one speed change per SETTLE_CYCLES+1 clk28 cycles.
REQ-011 Output timing:
- turbo changes only on the WAIT->SETTLE transition.
- clk_freeze rises in that same cycle and stays high exactly SETTLE_CYCLES cycles.
- busy = (state != IDLE), registered.
REQ-012 A safe-point ck35 arriving in the cycle WAIT is entered SHALL NOT apply; minimum IDLE-to-apply latency is 2 clk28 cycles.
REQ-013 All outputs registered; no combinational path from bus to outputs.

Reset
REQ-014 While rst is asserted: state=IDLE, turbo=TURBO_NONE, clk_freeze=0, busy=0, src=0, port #FE timer=0, basic48 flag=0, settle counter=0.
REQ-015 Reset mid-SETTLE SHALL drop clk_freeze immediately (asynchronous); the first change after release follows REQ-007.

Structure
REQ-016 turbo_t and its values (TURBO_NONE, TURBO_14, ...) SHALL come from the shared package common; the state enum and src encoding are local to the module.
REQ-017 The port #FE hold timer SHALL be a separate sub-module, hold_timer (load, tick enable, running flag), parameterised by width and terminal count.

Verification
REQ-018 cfg_turbo=TURBO_14, autoturbo_en=0, bus idle -> turbo=TURBO_14 at the first ck35 after reset release; clk_freeze high exactly 8 cycles.
REQ-019 autoturbo_en=1, cfg_turbo=TURBO_14, write to port #FE -> turbo=TURBO_NONE at the next safe point; returns to TURBO_14 4095 ck35 ticks after the last #FE access.
REQ-020 autoturbo_en=1, div_paged=1, magic_map=0, port #FE timer running -> turbo=TURBO_14, src=3.
- Setting magic_map=1 with cfg_turbo=TURBO_NONE and the timer idle -> TURBO_NONE, src=0.
REQ-021 Request changes in WAIT, with bus.mreq held for 3 ck35 strobes -> no change until the first strobe with mreq low.
- A request that reverts before that strobe -> no change and no clk_freeze pulse.
REQ-022 cfg_turbo toggled every clk28 cycle -> turbo changes at most once per 9 cycles; clk_freeze never has a high run longer than 8 cycles.
REQ-023 rst asserted at SETTLE count 4 -> clk_freeze=0, turbo=TURBO_NONE in the same cycle, state=IDLE.

Source files
------------

// File: rtl/common_pkg.sv
// common: shared turbo speed and CPU bus types
package common;
  typedef enum logic [1:0] {
    TURBO_NONE = 2'd0,
    TURBO_7    = 2'd1,
    TURBO_14   = 2'd2,
    TURBO_28   = 2'd3
  } turbo_t;
  typedef struct packed {
    logic [15:0] a;
    logic        mreq;
    logic        ioreq;
    logic        m1;
    logic        rd;
    logic        wr;
  } cpu_bus;
endpackage

// File: rtl/turbo_sched_hold_timer.sv
// hold_timer: counter loaded to 1, advancing on tick while non-zero, wrapping TERM->0
module hold_timer #(
  parameter int W = 12,
  parameter logic [W-1:0] TERM = '1
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic tick_i,
  output logic run_o
);
  logic [W-1:0] cnt_q, cnt_d;
  assign run_o = cnt_q != '0;
  always_comb cnt_d = load_i ? W'(1) : (tick_i && run_o) ? (cnt_q == TERM ? '0 : cnt_q + 1'b1) : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/turbo_sched.sv
// turbo_sched: picks the CPU speed from config and auto sources, applies it at a bus-safe ck35 point
module turbo_sched
  import common::*;
#(
  parameter logic [11:0] PORTFE_HOLD   = 12'd4095,
  parameter logic [3:0]  SETTLE_CYCLES = 4'd8
) (
  input  logic       clk28,
  input  logic       rst,
  input  logic       ck35,
  input  cpu_bus     bus,
  input  turbo_t     cfg_turbo,
  input  logic       autoturbo_en,
  input  logic       div_paged,
  input  logic       magic_map,
  input  logic       basic48_paged,
  output turbo_t     turbo,
  output logic       clk_freeze,
  output logic       busy,
  output logic [1:0] src
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SETTLE} state_t;
  localparam logic [1:0] SRC_CFG = 2'd0, SRC_B48 = 2'd1, SRC_FE = 2'd2, SRC_DIV = 2'd3;
  state_t     state_q, state_d;
  turbo_t     turbo_q, turbo_d, req_turbo;
  logic [1:0] src_q, src_d, req_src;
  logic [3:0] cnt_q, cnt_d;
  logic       freeze_q, freeze_d, busy_q, b48_q, b48_d, b48_hit, fe_run, div_win, safe;
  logic       unused;
  assign unused = ^{bus.rd, bus.wr, bus.a[5:1]};
  hold_timer #(.W(12), .TERM(PORTFE_HOLD)) u_fe (
    .clk(clk28),
    .rst(rst),
    .load_i(bus.ioreq && !bus.a[0]),
    .tick_i(ck35),
    .run_o(fe_run)
  );
  always_comb begin
    b48_hit   = basic48_paged && bus.m1 && bus.a[15:6] == 10'b0001000111;
    b48_d     = b48_hit ? 1'b1 : (!basic48_paged || bus.m1) ? 1'b0 : b48_q;
    div_win   = autoturbo_en && div_paged && !magic_map;
    req_turbo = div_win ? TURBO_14 : (autoturbo_en && fe_run) ? TURBO_NONE :
                (autoturbo_en && b48_q) ? TURBO_14 : cfg_turbo;
    req_src   = div_win ? SRC_DIV : (autoturbo_en && fe_run) ? SRC_FE :
                (autoturbo_en && b48_q) ? SRC_B48 : SRC_CFG;
    safe      = ck35 && !bus.mreq && !bus.ioreq;
    state_d   = state_q;
    turbo_d   = turbo_q;
    src_d     = src_q;
    freeze_d  = freeze_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      S_IDLE: if (req_turbo != turbo_q) state_d = S_WAIT;
      S_WAIT:
        if (req_turbo == turbo_q) state_d = S_IDLE;
        else if (safe) begin
          state_d  = S_SETTLE;
          turbo_d  = req_turbo;
          src_d    = req_src;
          freeze_d = 1'b1;
          cnt_d    = SETTLE_CYCLES;
        end
      S_SETTLE: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          freeze_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk28 or posedge rst)
    if (rst) begin
      state_q  <= S_IDLE;
      turbo_q  <= TURBO_NONE;
      src_q    <= SRC_CFG;
      freeze_q <= 1'b0;
      busy_q   <= 1'b0;
      cnt_q    <= 4'd0;
      b48_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      turbo_q  <= turbo_d;
      src_q    <= src_d;
      freeze_q <= freeze_d;
      busy_q   <= state_d != S_IDLE;
      cnt_q    <= cnt_d;
      b48_q    <= b48_d;
    end
  assign turbo      = turbo_q;
  assign src        = src_q;
  assign clk_freeze = freeze_q;
  assign busy       = busy_q;
endmodule

// File: tb/tb_turbo_sched.sv
// tb_turbo_sched: scoreboard bench; expected speed changes are queued and popped by a change monitor
module tb_turbo_sched;
  import common::*;
  typedef struct {turbo_t t; logic [1:0] s;} exp_t;
  typedef struct {logic paged; logic m1; logic [15:0] a; turbo_t t; logic [1:0] s;} b48_step_t;
  logic       clk28 = 0, rst = 0, ck35 = 0;
  cpu_bus     bus = '0;
  turbo_t     cfg_turbo = TURBO_14;
  logic       autoturbo_en = 0, div_paged = 0, magic_map = 0, basic48_paged = 0;
  turbo_t     turbo;
  logic       clk_freeze, busy;
  logic [1:0] src;
  exp_t       exp_q[$];
  int         checks = 0, errors = 0;
  int         ck_cnt = 0, ck_div = 0, changes = 0, chg_ck = 0;
  bit         free_run = 0, freeze_seen = 0;

  turbo_sched dut (
    .clk28(clk28), .rst(rst), .ck35(ck35), .bus(bus), .cfg_turbo(cfg_turbo),
    .autoturbo_en(autoturbo_en), .div_paged(div_paged), .magic_map(magic_map),
    .basic48_paged(basic48_paged), .turbo(turbo), .clk_freeze(clk_freeze),
    .busy(busy), .src(src)
  );

  always #5 clk28 = ~clk28;

  always @(negedge clk28) begin
    ck_div = (ck_div + 1) % 8;
    ck35 = ck_div == 0;
    if (ck_div == 0) ck_cnt++;
  end

  task automatic monitor();
    int run = 0, last = -100, cyc = 0;
    turbo_t prev = TURBO_NONE;
    exp_t e;
    forever begin
      @(negedge clk28);
      cyc++;
      if (rst) begin
        prev = turbo; run = 0; last = -100;
      end else begin
        if (clk_freeze) begin
          run++; freeze_seen = 1;
        end else if (run != 0) begin
          checks++;
          if (run != 8) begin errors++; $display("FAIL freeze_run: got %0d cycles want 8", run); end
          run = 0;
        end
        if (turbo !== prev) begin
          checks++;
          if (cyc - last < 9) begin errors++; $display("FAIL change_spacing: got %0d cycles want >=9", cyc - last); end
          checks++;
          if (run != 1) begin errors++; $display("FAIL freeze_with_change: freeze run %0d at change want 1", run); end
          checks++;
          if (free_run) begin
            if (src !== 2'd0 || (turbo !== TURBO_NONE && turbo !== TURBO_14)) begin
              errors++; $display("FAIL toggle_value: got turbo %0d src %0d", turbo, src);
            end
          end else if (exp_q.size() == 0) begin
            errors++; $display("FAIL unexpected_change: got turbo %0d src %0d want none", turbo, src);
          end else begin
            e = exp_q.pop_front();
            if (turbo !== e.t || src !== e.s) begin
              errors++; $display("FAIL change_value: got turbo %0d src %0d want turbo %0d src %0d", turbo, src, e.t, e.s);
            end
          end
          last = cyc; prev = turbo; changes++; chg_ck = ck_cnt;
        end
      end
    end
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk28); #1;
      ok = exp_q.size() == 0 && !busy;
    end
  endtask

  task automatic fe_access();
    bus.ioreq = 1; bus.wr = 1; bus.a = 16'h00FE;
    @(negedge clk28); #1;
    bus = '0;
  endtask

  task automatic test_reset();
    bit ok;
    int s;
    repeat (3) @(negedge clk28);
    #1;
    checks++; if (turbo !== TURBO_NONE) begin errors++; $display("FAIL reset_turbo: got %0d want %0d", turbo, TURBO_NONE); end
    checks++; if (clk_freeze !== 1'b0) begin errors++; $display("FAIL reset_freeze: got %0b want 0", clk_freeze); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++; if (src !== 2'd0) begin errors++; $display("FAIL reset_src: got %0d want 0", src); end
    exp_q.push_back('{TURBO_14, 2'd0});
    s = ck_cnt;
    rst = 0;
    wait_done(60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL first_change_timeout: got pending %0d want 0", exp_q.size()); end
    checks++; if (chg_ck - s != 1) begin errors++; $display("FAIL first_change_latency: got %0d ck35 strobes want 1", chg_ck - s); end
  endtask

  task automatic test_basic48();
    bit ok;
    b48_step_t steps[6] = '{
      '{1'b1, 1'b1, 16'h11C0, TURBO_14,   2'd1},
      '{1'b1, 1'b1, 16'h0000, TURBO_NONE, 2'd0},
      '{1'b1, 1'b1, 16'h11FF, TURBO_14,   2'd1},
      '{1'b1, 1'b0, 16'h2000, TURBO_14,   2'd1},
      '{1'b0, 1'b0, 16'h0000, TURBO_NONE, 2'd0},
      '{1'b1, 1'b1, 16'h1180, TURBO_NONE, 2'd0}
    };
    autoturbo_en = 1; cfg_turbo = TURBO_NONE;
    exp_q.push_back('{TURBO_NONE, 2'd0});
    wait_done(60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b48_setup_timeout: got pending %0d want 0", exp_q.size()); end
    foreach (steps[i]) begin
      if (steps[i].t != turbo) exp_q.push_back('{steps[i].t, steps[i].s});
      basic48_paged = steps[i].paged; bus.m1 = steps[i].m1; bus.a = steps[i].a;
      @(negedge clk28); #1;
      bus = '0;
      repeat (24) @(negedge clk28);
      wait_done(40, ok);
      checks++;
      if (!ok || turbo !== steps[i].t || src !== steps[i].s) begin
        errors++; $display("FAIL b48_step%0d: got turbo %0d src %0d want turbo %0d src %0d", i, turbo, src, steps[i].t, steps[i].s);
      end
    end
    autoturbo_en = 0; basic48_paged = 0;
  endtask

  task automatic test_wait_mreq();
    bit ok;
    int s;
    bus.mreq = 1; cfg_turbo = TURBO_14;
    s = ck_cnt;
    for (int i = 0; i < 60 && ck_cnt < s + 3; i++) @(negedge clk28);
    repeat (2) @(negedge clk28);
    #1;
    checks++; if (turbo !== TURBO_NONE) begin errors++; $display("FAIL mreq_hold_turbo: got %0d want %0d", turbo, TURBO_NONE); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mreq_hold_busy: got %0b want 1", busy); end
    checks++; if (clk_freeze !== 1'b0) begin errors++; $display("FAIL mreq_hold_freeze: got %0b want 0", clk_freeze); end
    exp_q.push_back('{TURBO_14, 2'd0});
    s = ck_cnt;
    bus.mreq = 0;
    wait_done(40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mreq_release_timeout: got pending %0d want 0", exp_q.size()); end
    checks++; if (chg_ck - s != 1) begin errors++; $display("FAIL mreq_release_latency: got %0d strobes want 1", chg_ck - s); end
    freeze_seen = 0;
    bus.mreq = 1; cfg_turbo = TURBO_NONE;
    repeat (3) @(negedge clk28);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL revert_wait_busy: got %0b want 1", busy); end
    cfg_turbo = TURBO_14;
    repeat (2) @(negedge clk28);
    #1 bus.mreq = 0;
    repeat (20) @(negedge clk28);
    #1;
    checks++;
    if (turbo !== TURBO_14 || freeze_seen || busy !== 1'b0) begin
      errors++; $display("FAIL revert_no_change: got turbo %0d freeze_seen %0b busy %0b want %0d 0 0", turbo, freeze_seen, busy, TURBO_14);
    end
  endtask

  task automatic test_magic_div();
    bit ok;
    autoturbo_en = 1; div_paged = 1; magic_map = 1; cfg_turbo = TURBO_NONE;
    exp_q.push_back('{TURBO_NONE, 2'd0});
    wait_done(60, ok);
    checks++; if (!ok || src !== 2'd0) begin errors++; $display("FAIL magic_blocks_div: got src %0d pending %0d want src 0", src, exp_q.size()); end
    magic_map = 0;
    exp_q.push_back('{TURBO_14, 2'd3});
    wait_done(60, ok);
    checks++; if (!ok || src !== 2'd3) begin errors++; $display("FAIL div_wins: got src %0d pending %0d want src 3", src, exp_q.size()); end
    fe_access();
    repeat (24) @(negedge clk28);
    #1;
    checks++; if (turbo !== TURBO_14 || src !== 2'd3) begin errors++; $display("FAIL div_over_portfe: got turbo %0d src %0d want %0d 3", turbo, src, TURBO_14); end
    div_paged = 0;
    exp_q.push_back('{TURBO_NONE, 2'd2});
    wait_done(60, ok);
    checks++; if (!ok || src !== 2'd2) begin errors++; $display("FAIL portfe_after_div: got src %0d pending %0d want src 2", src, exp_q.size()); end
  endtask

  task automatic test_portfe();
    bit ok;
    int s;
    cfg_turbo = TURBO_14;
    fe_access();
    repeat (800) @(negedge clk28);
    #1;
    checks++; if (turbo !== TURBO_NONE) begin errors++; $display("FAIL portfe_hold: got %0d want %0d", turbo, TURBO_NONE); end
    exp_q.push_back('{TURBO_14, 2'd0});
    bus.ioreq = 1; bus.wr = 1; bus.a = 16'h00FE;
    s = ck_cnt;
    @(negedge clk28); #1;
    bus = '0;
    wait_done(34000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL portfe_expire_timeout: got pending %0d want 0", exp_q.size()); end
    checks++; if (chg_ck - s != 4096) begin errors++; $display("FAIL portfe_expire_ticks: got %0d strobes want 4096", chg_ck - s); end
    autoturbo_en = 0;
  endtask

  task automatic test_back_to_back();
    int c0;
    free_run = 1;
    c0 = changes;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk28); #1;
      cfg_turbo = (cfg_turbo == TURBO_NONE) ? TURBO_14 : TURBO_NONE;
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk28); #1;
      cfg_turbo = turbo;
    end
    free_run = 0;
    checks++; if (changes - c0 > 23) begin errors++; $display("FAIL toggle_rate: got %0d changes want <=23", changes - c0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL toggle_settled: got busy %0b want 0", busy); end
  endtask

  task automatic test_reset_mid_settle();
    bit ok;
    cfg_turbo = TURBO_NONE;
    if (turbo != TURBO_NONE) exp_q.push_back('{TURBO_NONE, 2'd0});
    wait_done(60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rms_setup_timeout: got pending %0d want 0", exp_q.size()); end
    cfg_turbo = TURBO_14;
    exp_q.push_back('{TURBO_14, 2'd0});
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin @(negedge clk28); #1; ok = clk_freeze; end
    checks++; if (!ok) begin errors++; $display("FAIL rms_freeze_timeout: got freeze %0b want 1", clk_freeze); end
    repeat (4) @(negedge clk28);
    #1 rst = 1;
    #1;
    checks++;
    if (clk_freeze !== 1'b0 || turbo !== TURBO_NONE || busy !== 1'b0 || src !== 2'd0) begin
      errors++; $display("FAIL rms_async: got freeze %0b turbo %0d busy %0b src %0d want 0 %0d 0 0", clk_freeze, turbo, busy, src, TURBO_NONE);
    end
    repeat (2) @(negedge clk28);
    #1 rst = 0;
    exp_q.push_back('{TURBO_14, 2'd0});
    wait_done(60, ok);
    checks++; if (!ok || turbo !== TURBO_14) begin errors++; $display("FAIL rms_after_release: got turbo %0d pending %0d want %0d", turbo, exp_q.size(), TURBO_14); end
  endtask

  initial begin
    #1 rst = 1;
    fork monitor(); join_none
    test_reset();
    test_basic48();
    test_wait_mreq();
    test_magic_div();
    test_portfe();
    test_back_to_back();
    test_reset_mid_settle();
    repeat (4) @(negedge clk28);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
